// File: rtl/lcd_pkg.sv
// Shared character constants and types for the LCD marquee slice.
package lcd_pkg;

   localparam int CHAR_W       = 8;
   localparam int LCD_LINE_LEN = 16;

   typedef logic [CHAR_W-1:0] char_t;

   localparam char_t ASCII_SPACE = 8'h20;

endpackage

// File: rtl/lcd_marquee_tick.sv
// Scroll-rate divider: pulses step once every TICK_DIV enabled clocks.
module marquee_tick #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic step
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0] cnt;
   logic          at_last;

   assign at_last = (cnt == CNT_LAST);
   // clr wins over a terminal count so a restart never leaks a step.
   assign step    = en & at_last & ~clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= at_last ? '0 : cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/lcd_marquee.sv
// Scrolling LCD marquee: message RAM, offset stepper and registered window.
// Define LCD_MARQUEE_BOUNCE_EN to ping-pong the window instead of wrapping.
module lcd_marquee
   import lcd_pkg::*;
#(
   parameter int MSG_LEN  = 32,
   parameter int WIN_LEN  = LCD_LINE_LEN,
   parameter int TICK_DIV = 50000000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      dir,
   input  logic                      restart,
   input  logic                      wr_en,
   input  logic [7:0]                wr_addr,
   input  logic [7:0]                wr_data,
   output logic [CHAR_W*WIN_LEN-1:0] win_out,
   output logic                      wrap
);

   localparam int OW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam logic [OW-1:0] OFF_LAST  = OW'(MSG_LEN - 1);
   localparam logic [OW-1:0] OFF_ONE   = OW'(1);
   localparam logic [OW:0]   MSG_LEN_X = (OW+1)'(MSG_LEN);
   localparam logic [8:0]    MSG_LEN_A = 9'(MSG_LEN);
`ifdef LCD_MARQUEE_BOUNCE_EN
   localparam logic [OW-1:0] OFF_BMAX  = OW'(MSG_LEN - WIN_LEN);
`endif

   char_t                     msg [MSG_LEN];
   logic [OW-1:0]             offset;
   logic                      step;
   logic [CHAR_W*WIN_LEN-1:0] win_nxt;
   logic [OW:0]               idx;
`ifdef LCD_MARQUEE_BOUNCE_EN
   logic                      bdir;
`endif

   marquee_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (restart),
      .step (step)
   );

   // NOTE: this array is small and must read as spaces during reset, so it is
   // flops with a reset rather than an inferred RAM (which cannot be reset).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MSG_LEN; i++) msg[i] <= ASCII_SPACE;
      end else if (wr_en && ({1'b0, wr_addr} < MSG_LEN_A)) begin
         msg[wr_addr[OW-1:0]] <= wr_data;
      end
   end

   // NOTE: combinational blocks use blocking '=' and assign defaults first so
   // no path leaves a variable unassigned (which would infer a latch).
   always_comb begin
      win_nxt = '0;
      idx     = '0;
      for (int i = 0; i < WIN_LEN; i++) begin
         idx = {1'b0, offset} + (OW+1)'(i);
         if (idx >= MSG_LEN_X) idx = idx - MSG_LEN_X;
         win_nxt[CHAR_W*(WIN_LEN-i)-1 -: CHAR_W] = msg[idx[OW-1:0]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_out <= {WIN_LEN{ASCII_SPACE}};
      end else begin
         win_out <= win_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         offset <= '0;
         wrap   <= 1'b0;
`ifdef LCD_MARQUEE_BOUNCE_EN
         bdir   <= dir;
`endif
      end else if (restart) begin
         offset <= '0;
         wrap   <= 1'b0;
`ifdef LCD_MARQUEE_BOUNCE_EN
         bdir   <= dir;
`endif
      end else begin
         wrap <= 1'b0;
         if (step) begin
`ifdef LCD_MARQUEE_BOUNCE_EN
            // Reverse on arriving at either end of 0..MSG_LEN-WIN_LEN.
            if (!bdir) begin
               if (offset < OFF_BMAX) offset <= offset + OFF_ONE;
               if (({1'b0, offset} + (OW+1)'(1)) >= {1'b0, OFF_BMAX}) begin
                  bdir <= 1'b1;
                  wrap <= 1'b1;
               end
            end else begin
               if (offset != '0) offset <= offset - OFF_ONE;
               if (offset <= OFF_ONE) begin
                  bdir <= 1'b0;
                  wrap <= 1'b1;
               end
            end
`else
            if (!dir) begin
               if (offset == OFF_LAST) begin
                  offset <= '0;
                  wrap   <= 1'b1;
               end else begin
                  offset <= offset + OFF_ONE;
               end
            end else begin
               if (offset == '0) begin
                  offset <= OFF_LAST;
                  wrap   <= 1'b1;
               end else begin
                  offset <= offset - OFF_ONE;
               end
            end
`endif
         end
      end
   end

endmodule
